// File: rtl/led_ctrl.sv
// Memory-mapped LED peripheral: per-LED enable, 8-bit PWM duty and a global blink timer.
// Optional blink logic is built only when LED_BLINK_EN is defined.
module led_ctrl #(
    parameter int NLED       = 4,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 24
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            sel,
    input  logic            mem_valid,
    input  logic [3:0]      mem_addr,
    input  logic [31:0]     mem_wdata,
    input  logic [3:0]      mem_wstrb,
    output logic            mem_ready,
    output logic [31:0]     mem_rdata,
    output logic [NLED-1:0] led
);

    logic                           ready_q;
    logic [31:0]                    rdata_q, rdata_d;
    logic [NLED-1:0]                en_q, en_d;
    logic [NLED-1:0][PWM_BITS-1:0]  duty_q, duty_d;
    logic [PWM_BITS-1:0]            pwm_cnt_q;
    logic [NLED-1:0]                led_q, led_d;
    logic [NLED-1:0]                pwm_on;
    logic                           blink_en;
    logic                           phase;

    // Ready in the previous cycle blocks a new access, so a held valid acks every other cycle.
    logic       access, wr;
    logic [1:0] widx;
    assign access = sel & mem_valid & ~ready_q;
    assign wr     = access & (|mem_wstrb);
    assign widx   = mem_addr[3:2];

    logic unused_addr;
    assign unused_addr = ^mem_addr[1:0];

`ifdef LED_BLINK_EN
    localparam logic [BLINK_BITS-1:0] ONE = {{(BLINK_BITS-1){1'b0}}, 1'b1};
    logic                  blink_en_q, blink_en_d;
    logic [BLINK_BITS-1:0] period_q, period_d;
    logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [31:0]           wmask;
    logic                  period_wr;

    assign wmask     = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    assign period_wr = wr && (widx == 2'd2);
    assign blink_en  = blink_en_q;
    assign phase     = phase_q;

    always_comb begin
        blink_en_d  = blink_en_q;
        period_d    = period_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (wr && widx == 2'd0 && mem_wstrb[1])
            blink_en_d = mem_wdata[8];
        if (period_wr)
            period_d = (period_q & ~wmask[BLINK_BITS-1:0]) | (mem_wdata[BLINK_BITS-1:0] & wmask[BLINK_BITS-1:0]);
        // A PERIOD write restarts the timer and overrides a coincident wrap.
        if (period_wr || period_q == '0) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == period_q - ONE) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_en_q  <= 1'b0;
            period_q    <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_en_q  <= blink_en_d;
            period_q    <= period_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    assign blink_en = 1'b0;
    assign phase    = 1'b1;
`endif

    always_comb begin
        en_d   = en_q;
        duty_d = duty_q;
        if (wr && widx == 2'd0 && mem_wstrb[0])
            en_d = mem_wdata[NLED-1:0];
        for (int i = 0; i < NLED; i++) begin
            if (wr && widx == 2'd1 && mem_wstrb[i])
                duty_d[i] = mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        for (int i = 0; i < NLED; i++)
            pwm_on[i] = duty_q[i] > pwm_cnt_q;
        led_d = en_q & pwm_on & {NLED{~blink_en | phase}};
    end

    always_comb begin
        rdata_d = '0;
        case (widx)
            2'd0: begin
                rdata_d[NLED-1:0] = en_q;
                rdata_d[8]        = blink_en;
            end
            2'd1: begin
                for (int i = 0; i < NLED; i++)
                    rdata_d[8*i +: 8] = duty_q[i];
            end
            2'd2: begin
`ifdef LED_BLINK_EN
                rdata_d[BLINK_BITS-1:0] = period_q;
`endif
            end
            default: begin
                rdata_d[NLED-1:0] = led_q;
                rdata_d[8]        = phase;
                rdata_d[23:16]    = pwm_cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            en_q      <= '0;
            duty_q    <= '1;
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            ready_q   <= access;
            rdata_q   <= access ? rdata_d : '0;
            en_q      <= en_d;
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            led_q     <= led_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl: register table, PWM duty counts, handshake, reset and blink sequences.
module tb_led_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  led;

    int errs   = 0;
    int checks = 0;

`ifdef LED_BLINK_EN
    localparam logic [31:0] CTRL_ALL = 32'h0000_010F;
    localparam logic [31:0] CTRL_B   = 32'h0000_0100;
    localparam logic [31:0] PER_ALL  = 32'h00FF_FFFF;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0000_000F;
    localparam logic [31:0] CTRL_B   = 32'h0000_0000;
    localparam logic [31:0] PER_ALL  = 32'h0000_0000;
`endif

    led_ctrl #(.NLED(4), .PWM_BITS(8), .BLINK_BITS(24)) dut (
        .clk(clk), .resetn(resetn), .sel(sel), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  idx;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
        logic [31:0] mask;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge following the idle cycle.
    task automatic bus(input string name, input logic [1:0] idx, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        sel = 1'b1; mem_valid = 1'b1; mem_addr = {idx, 2'b00}; mem_wdata = d; mem_wstrb = s;
        @(posedge clk); #1;
        chk({name, " ready"}, {31'd0, mem_ready}, 32'd1);
        r = mem_rdata;
        sel = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        chk({name, " idle"}, {mem_ready, mem_rdata[30:0]}, 32'd0);
    endtask

    vec_t        tbl [20];
    logic [31:0] rd;
    int          cnt [4];
    int          bad;

    initial begin
        tbl[0]  = '{"rst ctrl",    2'd0, 1'b0, 32'h0,           4'h0, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[1]  = '{"rst duty",    2'd1, 1'b0, 32'h0,           4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[2]  = '{"rst period",  2'd2, 1'b0, 32'h0,           4'h0, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[3]  = '{"wr duty b1",  2'd1, 1'b1, 32'h1122_3344,   4'h2, 32'h0,         32'h0};
        tbl[4]  = '{"duty strb",   2'd1, 1'b0, 32'h0,           4'h0, 32'hFFFF_33FF, 32'hFFFF_FFFF};
        tbl[5]  = '{"wr ctrl",     2'd0, 1'b1, 32'hFFFF_FFFF,   4'hF, 32'h0,         32'h0};
        tbl[6]  = '{"ctrl all",    2'd0, 1'b0, 32'h0,           4'h0, CTRL_ALL,      32'hFFFF_FFFF};
        tbl[7]  = '{"wr period",   2'd2, 1'b1, 32'hFFFF_FFFF,   4'hF, 32'h0,         32'h0};
        tbl[8]  = '{"period all",  2'd2, 1'b0, 32'h0,           4'h0, PER_ALL,       32'hFFFF_FFFF};
        tbl[9]  = '{"wr status",   2'd3, 1'b1, 32'hFFFF_FFFF,   4'hF, 32'h0,         32'h0};
        tbl[10] = '{"ctrl kept",   2'd0, 1'b0, 32'h0,           4'h0, CTRL_ALL,      32'hFFFF_FFFF};
        tbl[11] = '{"duty kept",   2'd1, 1'b0, 32'h0,           4'h0, 32'hFFFF_33FF, 32'hFFFF_FFFF};
        tbl[12] = '{"period kept", 2'd2, 1'b0, 32'h0,           4'h0, PER_ALL,       32'hFFFF_FFFF};
        tbl[13] = '{"wr ctrl b0",  2'd0, 1'b1, 32'h0,           4'h1, 32'h0,         32'h0};
        tbl[14] = '{"ctrl lane0",  2'd0, 1'b0, 32'h0,           4'h0, CTRL_B,        32'hFFFF_FFFF};
        tbl[15] = '{"wr ctrl 0",   2'd0, 1'b1, 32'h0,           4'hF, 32'h0,         32'h0};
        tbl[16] = '{"ctrl zero",   2'd0, 1'b0, 32'h0,           4'h0, 32'h0,         32'hFFFF_FFFF};
        tbl[17] = '{"wr period 0", 2'd2, 1'b1, 32'h0,           4'hF, 32'h0,         32'h0};
        tbl[18] = '{"period zero", 2'd2, 1'b0, 32'h0,           4'h0, 32'h0,         32'hFFFF_FFFF};
        tbl[19] = '{"status idle", 2'd3, 1'b0, 32'h0,           4'h0, 32'h0000_0100, 32'h0000_FFFF};

        resetn = 1'b0; sel = 1'b0; mem_valid = 1'b0;
        mem_addr = 4'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        #12;
        chk("reset outs", {mem_ready, led, mem_rdata[26:0]}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            bus(tbl[i].name, tbl[i].idx, tbl[i].wdata, tbl[i].wr ? tbl[i].wstrb : 4'h0, rd);
            if (!tbl[i].wr)
                chk(tbl[i].name, rd & tbl[i].mask, tbl[i].exp);
        end

        // PWM duty: every 256-cycle window holds exactly duty high cycles.
        bus("pwm duty", 2'd1, 32'h8040_FF00, 4'hF, rd);
        bus("pwm ctrl", 2'd0, 32'h0000_000F, 4'hF, rd);
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        for (int c = 0; c < 256; c++) begin
            for (int k = 0; k < 4; k++) cnt[k] += int'(led[k]);
            @(posedge clk); #1;
        end
        chk("pwm led0", cnt[0], 0);
        chk("pwm led1", cnt[1], 255);
        chk("pwm led2", cnt[2], 64);
        chk("pwm led3", cnt[3], 128);

        // Held valid acks every other cycle.
        sel = 1'b1; mem_valid = 1'b1; mem_addr = 4'h0; mem_wstrb = 4'h0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("hs cyc%0d", c), {31'd0, mem_ready}, 32'(c % 2));
            @(posedge clk); #1;
        end
        sel = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #1;
        sel = 1'b0; mem_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            bad += int'(mem_ready);
        end
        chk("no sel ready", bad, 0);
        mem_valid = 1'b0;
        @(posedge clk); #1;

        // Reset while a read response is on the bus.
        sel = 1'b1; mem_valid = 1'b1; mem_addr = 4'h4; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        chk("mid ready", {31'd0, mem_ready}, 32'd1);
        resetn = 1'b0; sel = 1'b0; mem_valid = 1'b0;
        #1;
        chk("mid rst outs", {mem_ready, led, mem_rdata[26:0]}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        bus("post ctrl", 2'd0, 32'h0, 4'h0, rd);
        chk("post ctrl", rd, 32'h0);
        bus("post duty", 2'd1, 32'h0, 4'h0, rd);
        chk("post duty", rd, 32'hFFFF_FFFF);
        bus("post period", 2'd2, 32'h0, 4'h0, rd);
        chk("post period", rd, 32'h0);

`ifdef LED_BLINK_EN
        bus("bl duty", 2'd1, 32'h0000_00FF, 4'hF, rd);
        bus("bl ctrl", 2'd0, 32'h0000_0101, 4'hF, rd);
        bus("bl period", 2'd2, 32'd10, 4'hF, rd);
        // Commit edge E is one cycle back; led high for E+1..E+10, low E+11..E+20, and so on.
        bad = 0;
        for (int c = 1; c <= 40; c++) begin
            if (led[0] !== (((c - 1) / 10) % 2 == 0)) bad++;
            @(posedge clk); #1;
        end
        chk("blink pattern", bad > 1, 1'b0);
        // Now just after E+41; rewrite PERIOD so it commits on the E+50 wrap edge.
        repeat (8) @(posedge clk);
        #1;
        bus("bl rewrite", 2'd2, 32'd10, 4'hF, rd);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            bad += int'(!led[0]);
            @(posedge clk); #1;
        end
        chk("wrap no toggle", bad > 1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
